// File: rtl/drain_sequencer_pkg.sv
// Shared types and defaults for the capture-RAM drain sequencer.
package drain_sequencer_pkg;

  localparam int DEF_PTR_BITS    = 5;
  localparam int DEF_SLOT_BITS   = 3;
  localparam int DEF_FRAME_BYTES = 6;

  // Appended after each frame when the terminator option is built in.
  localparam logic [7:0] TERM_BYTE = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    SEND,
    HOLD,
    WAIT_TX,
    TERM,
    DONE
  } state_e;

endpackage

// File: rtl/drain_sequencer_if.sv
// Bundle of ring-pointer, capture-RAM and uart_tx signals seen by the drain sequencer.
interface drain_sequencer_if #(
  parameter int PTR_BITS  = drain_sequencer_pkg::DEF_PTR_BITS,
  parameter int SLOT_BITS = drain_sequencer_pkg::DEF_SLOT_BITS
);

  logic [PTR_BITS-1:0]           write_ptr;
  logic [PTR_BITS-1:0]           read_ptr;
  logic                          read_done;
  logic [PTR_BITS+SLOT_BITS-1:0] ram_addr;
  logic                          ram_read;
  logic [7:0]                    ram_data;
  logic                          uart_ready;
  logic [7:0]                    uart_data;
  logic                          uart_latch;

  modport master (
    input  write_ptr, ram_data, uart_ready,
    output read_ptr, read_done, ram_addr, ram_read, uart_data, uart_latch
  );

  modport slave (
    output write_ptr, ram_data, uart_ready,
    input  read_ptr, read_done, ram_addr, ram_read, uart_data, uart_latch
  );

endinterface

// File: rtl/drain_sequencer.sv
// Drains the oldest capture-RAM slot byte by byte to uart_tx (3 cycles !empty->first latch, >=5 cycles/byte),
// stalling in SEND/WAIT_TX while uart_ready is low. DRAIN_TERMINATOR_EN appends TERM_BYTE to every slot.
module drain_sequencer
  import drain_sequencer_pkg::*;
#(
  parameter int PTR_BITS    = DEF_PTR_BITS,
  parameter int SLOT_BITS   = DEF_SLOT_BITS,
  parameter int FRAME_BYTES = DEF_FRAME_BYTES
) (
  input  logic              clock,
  input  logic              reset,
  drain_sequencer_if.master bus
);

  localparam logic [SLOT_BITS-1:0] LAST_IDX = SLOT_BITS'(FRAME_BYTES - 1);

  state_e               state_q, state_d;
  logic [PTR_BITS-1:0]  read_ptr_q, read_ptr_d;
  logic [SLOT_BITS-1:0] byte_idx_q, byte_idx_d;
  logic [7:0]           uart_data_q, uart_data_d;

  logic empty;
  logic last_byte;
  logic ram_read;
  logic uart_latch;
  logic read_done;

`ifdef DRAIN_TERMINATOR_EN
  logic term_sent_q, term_sent_d;
`endif

  assign empty     = (read_ptr_q == bus.write_ptr);
  assign last_byte = (byte_idx_q == LAST_IDX);

  assign bus.read_ptr   = read_ptr_q;
  assign bus.ram_addr   = {read_ptr_q, byte_idx_q};
  assign bus.ram_read   = ram_read;
  assign bus.uart_data  = uart_data_q;
  assign bus.uart_latch = uart_latch;
  assign bus.read_done  = read_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_ptr_q  <= '0;
      byte_idx_q  <= '0;
      uart_data_q <= 8'h00;
`ifdef DRAIN_TERMINATOR_EN
      term_sent_q <= 1'b0;
`endif
    end else begin
      read_ptr_q  <= read_ptr_d;
      byte_idx_q  <= byte_idx_d;
      uart_data_q <= uart_data_d;
`ifdef DRAIN_TERMINATOR_EN
      term_sent_q <= term_sent_d;
`endif
    end
  end

  // write_ptr is only looked at in IDLE, so a producer advancing mid-frame cannot disturb the slot in flight.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!empty) state_d = FETCH;
      FETCH:     state_d = WAIT_DATA;
      WAIT_DATA: state_d = SEND;
      SEND:      if (bus.uart_ready) state_d = HOLD;
      HOLD:      state_d = WAIT_TX;
      WAIT_TX: begin
        if (bus.uart_ready) begin
          if (!last_byte) begin
            state_d = FETCH;
`ifdef DRAIN_TERMINATOR_EN
          end else if (!term_sent_q) begin
            state_d = TERM;
`endif
          end else begin
            state_d = DONE;
          end
        end
      end
`ifdef DRAIN_TERMINATOR_EN
      TERM:      state_d = SEND;
`endif
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    read_ptr_d  = read_ptr_q;
    byte_idx_d  = byte_idx_q;
    uart_data_d = uart_data_q;
    ram_read    = 1'b0;
    uart_latch  = 1'b0;
    read_done   = 1'b0;
`ifdef DRAIN_TERMINATOR_EN
    term_sent_d = term_sent_q;
`endif
    unique case (state_q)
      FETCH:     ram_read = 1'b1;
      WAIT_DATA: uart_data_d = bus.ram_data;
      SEND:      uart_latch = bus.uart_ready;
      WAIT_TX: begin
        if (bus.uart_ready && !last_byte) begin
          byte_idx_d = byte_idx_q + SLOT_BITS'(1);
        end
      end
`ifdef DRAIN_TERMINATOR_EN
      TERM: begin
        uart_data_d = TERM_BYTE;
        term_sent_d = 1'b1;
      end
`endif
      DONE: begin
        read_ptr_d = read_ptr_q + PTR_BITS'(1);
        byte_idx_d = '0;
        read_done  = 1'b1;
`ifdef DRAIN_TERMINATOR_EN
        term_sent_d = 1'b0;
`endif
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  strobes_exclusive: assert property (@(posedge clock) disable iff (!reset)
    $onehot0({ram_read, uart_latch, read_done}));
`endif

endmodule

// File: doc/drain_sequencer.md
Name: drain_sequencer

Overview:
Sequencer that drains captured LPC frames from the shared capture RAM to the UART transmitter. Capture RAM is organised as ring slots of 2**SLOT_BITS bytes, of which FRAME_BYTES are valid. The block compares its read slot pointer against the producer's write slot pointer, fetches each valid byte of the oldest slot, and hands bytes one at a time to uart_tx via a ready/latch handshake. After the last byte of a slot it advances the read pointer and pulses read_done to the ring-buffer bookkeeping.

Parameters:
PTR_BITS, 5, width of ring slot pointers (2**PTR_BITS slots)
SLOT_BITS, 3, log2 bytes per slot; RAM address width = PTR_BITS+SLOT_BITS
FRAME_BYTES, 6, valid bytes per slot, 1..2**SLOT_BITS

Ports:
clock  in  1  system clock (ext_clock domain)
reset  in  1  asynchronous, active-low reset
write_ptr  in  PTR_BITS  producer slot pointer, already synchronous to clock
read_ptr  out  PTR_BITS  current read slot
read_done  out  1  one-cycle pulse when a slot is fully sent
ram_addr  out  PTR_BITS+SLOT_BITS  {read_ptr, byte_idx}
ram_read  out  1  read strobe; ram_data valid the cycle after
ram_data  in  8  RAM read data
uart_ready  in  1  transmitter idle and able to accept a byte
uart_data  out  8  byte to send, held stable while uart_latch high
uart_latch  out  1  one-cycle load strobe to transmitter

Behaviour:
- Reset (reset low, async): state IDLE; read_ptr=0, byte_idx=0, ram_addr=0, uart_data=0x00; read_done, ram_read, uart_latch = 0.
- empty = (read_ptr == write_ptr), evaluated combinationally each cycle.
- IDLE: if !empty -> FETCH; else stay.
- FETCH: ram_addr={read_ptr,byte_idx}, ram_read=1 for one cycle -> WAIT_DATA.
- WAIT_DATA: capture ram_data into uart_data -> SEND.
- SEND: wait for uart_ready=1; in that cycle uart_latch=1 (one cycle) -> HOLD.
- HOLD: one-cycle guard, uart_ready ignored (transmitter drops ready the cycle after latch) -> WAIT_TX.
- WAIT_TX: wait uart_ready=1. If byte_idx==FRAME_BYTES-1 -> DONE; else byte_idx+=1 -> FETCH.
- DONE: read_ptr+=1 mod 2**PTR_BITS (wraps 31->0), byte_idx=0, read_done=1 for exactly one cycle -> IDLE.
- Minimum cost per byte: 5 cycles plus transmitter time; latency from !empty to first uart_latch = 3 cycles when uart_ready already high.
- write_ptr changing mid-frame does not affect the slot being drained; empty only sampled in IDLE.
- Producer overrunning read_ptr (overflow) is not detected here; the slot is sent as read.
- Bytes at offsets FRAME_BYTES..2**SLOT_BITS-1 are never read.
- Reset asserted mid-frame: immediate return to reset values; partially sent frame is abandoned, no read_done.
- uart_latch, ram_read, read_done never asserted together.

Optional Feature:
DRAIN_TERMINATOR_EN: defined -> after the last data byte and before DONE, an extra TERM state sends TERM_BYTE (0x0A) using the same SEND/HOLD/WAIT_TX handshake (FRAME_BYTES+1 latches per slot). Undefined -> exactly FRAME_BYTES latches per slot, no TERM state present.

Decomposition:
- Shared package: state enum (IDLE, FETCH, WAIT_DATA, SEND, HOLD, WAIT_TX, TERM, DONE), TERM_BYTE=8'h0A, default PTR_BITS/SLOT_BITS/FRAME_BYTES constants.
- No sub-module. Handshake is small enough to remain inline in the single FSM.

Test Plan:
- Reset: reset low with write_ptr=3 -> all outputs 0, read_ptr=0. Release -> first ram_read with ram_addr=0x00 within 1 cycle.
- Single frame: RAM slot0 = 11 22 33 44 55 66, write_ptr 0->1, uart_ready tied high with 1-cycle drop after latch -> uart_data 11..66 in order, 6 latches, one read_done, read_ptr=1, then idle.
- Backpressure: uart_ready held low 200 cycles after first latch -> no second latch until ready returns; uart_data stable throughout.
- Wrap: read_ptr=31, write_ptr=0 -> slot 31 sent (ram_addr 0xF8..0xFD), read_ptr wraps to 0, stops.
- Reset mid-frame: assert reset after 3rd latch -> outputs reset immediately, no read_done; after release slot 0 restarts at byte 0.
- DRAIN_TERMINATOR_EN defined: single-frame case -> 7 latches, last uart_data=0x0A before read_done.
